memory_game_ctrl: RTL
=====================

Name: memory_game_ctrl

Overview:
Parametrised round/level controller for the memorization game. It replaces the single-shot compare-and-display flow with a multi-round game: it captures a DIGITS-wide hex secret from the random source, shows it for a level-dependent window, collects keypad digits one at a time, and checks the entry. It also tracks level, lives and score. It sits between randnum/keyboard_decoder and the display module.

Parameters:
DIGITS, 4, hex digits per secret (1..8); secret width is 4*DIGITS
MAX_LEVEL, 9, highest level; level saturates here
LIVES, 3, lives granted at game start (1..7)
SHOW_CYCLES, 200000000, display window at level 1, in clk cycles
SHOW_STEP, 20000000, cycles removed from the window per level above 1
MIN_SHOW, 40000000, floor on the display window
RESULT_CYCLES, 100000000, hold time of the result phase
SCORE_W, 10, score width; score saturates at all-ones

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset; sampled on rising clk
start  in  1  debounced start pulse, one cycle
rand_val  in  4*DIGITS  free-running random value
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  4  hex digit from keypad
key_clear  in  1  one-cycle strobe: discard the partial entry
rand_req  out  1  one-cycle pulse when the secret is captured
secret  out  4*DIGITS  current secret, shown during SHOW
entry  out  4*DIGITS  digits entered so far, right-aligned
entry_cnt  out  4  number of digits entered
phase  out  3  0 IDLE, 1 LOAD, 2 SHOW, 3 ENTRY, 4 CHECK, 5 RESULT, 6 OVER
correct  out  1  result of the last CHECK; valid in RESULT
level  out  4  current level (1..MAX_LEVEL); 0 in IDLE
lives  out  3  remaining lives
score  out  SCORE_W  accumulated score
game_over  out  1  high while in OVER

Behaviour:
- Reset (rst==0 at the clock edge): phase IDLE. All outputs are 0, including secret, entry, entry_cnt, correct, level, lives, score and rand_req. Reset takes effect from any state, including mid-SHOW and mid-ENTRY, and clears all internal counters.
- IDLE: on start -> LOAD. Load level=1, lives=LIVES, score=0.
- LOAD, 1 cycle:
  - secret<=rand_val; rand_req=1 for this cycle only.
  - entry<=0; entry_cnt<=0.
  - Load the show timer with show_len = max(MIN_SHOW, SHOW_CYCLES-(level-1)*SHOW_STEP). Compute this without underflow.
  - Go to SHOW.
- SHOW: timer decrements each cycle. Exit to ENTRY on the cycle after the timer reaches 1, so the total time in SHOW is exactly show_len cycles. Keys are ignored.
- ENTRY:
  - key_valid: entry<={entry[4*DIGITS-5:0],key_digit} and entry_cnt++.
  - key_clear: entry<=0, entry_cnt<=0. If key_clear and key_valid arrive in the same cycle, clear wins and the digit is dropped.
  - When entry_cnt becomes DIGITS, go to CHECK on the next cycle; further keys are ignored.
  - No timeout.
- CHECK, 1 cycle: correct<=(entry==secret). Load the result timer with RESULT_CYCLES. Go to RESULT.
- RESULT: hold for RESULT_CYCLES cycles; then apply the outcome.
  - correct=1: score += level (saturating). level <= min(level+1, MAX_LEVEL). -> LOAD.
  - correct=0, lives>1: lives--. level unchanged. -> LOAD.
  - correct=0, lives==1: lives<=0. -> OVER.
- OVER: game_over=1; level, score and secret are held. start -> same initialisation as from IDLE -> LOAD.
- start is ignored in every state except IDLE and OVER. key_valid and key_clear are ignored outside ENTRY.
- All outputs are registered; phase changes on the clock edge after the triggering condition.

Test Plan:
Test parameters: DIGITS=4, LIVES=2, SHOW_CYCLES=20, SHOW_STEP=4, MIN_SHOW=8, RESULT_CYCLES=5, MAX_LEVEL=4.
1. rst=0 for 2 cycles, then rst=1 -> every output is 0 and phase=0. start with rand_val=16'hA3C5 -> rand_req high for exactly 1 cycle, secret=A3C5, level=1, lives=2, phase=2 for exactly 20 cycles.
2. In ENTRY, keys A,3,C,5 -> entry=A3C5, CHECK then correct=1. After 5 RESULT cycles: score=1, level=2, next SHOW lasts 16 cycles.
3. Keys A,3, key_clear, then C,5,A,3 -> entry=C5A3, correct=0, lives=1, level unchanged. A second wrong entry -> phase=6, game_over=1, lives=0.
4. Win four times in a row -> level saturates at 4, score=1+2+3+4=10, SHOW at level 4 = max(8,8) = 8 cycles. A fifth win keeps level=4 and gives score=14.
5. key_valid and key_clear in the same cycle -> entry_cnt=0. Keys during SHOW and RESULT -> no change to entry. start during ENTRY -> ignored.
6. rst=0 asserted mid-ENTRY with entry_cnt=2 -> next cycle phase=0 and every output is 0. start from OVER -> score=0, lives=2, level=1.

Source files
------------

// File: rtl/memory_game_ctrl_if.sv
// Bus between the memory game controller and its random source, keypad decoder and display.
// key_valid/key_clear/start are one-cycle strobes with no backpressure; rand_req is a one-cycle notification.
interface memory_game_ctrl_if #(
    parameter int DIGITS  = 4,
    parameter int SCORE_W = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   rand_val;
    logic                  key_valid;
    logic [3:0]            key_digit;
    logic                  key_clear;
    logic                  rand_req;
    logic [4*DIGITS-1:0]   secret;
    logic [4*DIGITS-1:0]   entry;
    logic [3:0]            entry_cnt;
    logic [2:0]            phase;
    logic                  correct;
    logic [3:0]            level;
    logic [2:0]            lives;
    logic [SCORE_W-1:0]    score;
    logic                  game_over;

    modport master (
        output start, rand_val, key_valid, key_digit, key_clear,
        input  rand_req, secret, entry, entry_cnt, phase, correct,
               level, lives, score, game_over
    );

    modport slave (
        input  start, rand_val, key_valid, key_digit, key_clear,
        output rand_req, secret, entry, entry_cnt, phase, correct,
               level, lives, score, game_over
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Multi-round memory game controller: capture secret, show it, collect keypad entry,
// judge it and track level, lives and score. The FSM state is exported directly as phase.
module memory_game_ctrl #(
    parameter int DIGITS        = 4,
    parameter int MAX_LEVEL     = 9,
    parameter int LIVES         = 3,
    parameter int SHOW_CYCLES   = 200000000,
    parameter int SHOW_STEP     = 20000000,
    parameter int MIN_SHOW      = 40000000,
    parameter int RESULT_CYCLES = 100000000,
    parameter int SCORE_W       = 10
) (
    input logic clk,
    input logic rst,
    memory_game_ctrl_if.slave bus
);
    localparam int EW      = 4 * DIGITS;
    localparam int MAX_A   = (SHOW_CYCLES > MIN_SHOW) ? SHOW_CYCLES : MIN_SHOW;
    localparam int MAX_CYC = (MAX_A > RESULT_CYCLES) ? MAX_A : RESULT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHOW   = 3'd2,
        ENTRY  = 3'd3,
        CHECK  = 3'd4,
        RESULT = 3'd5,
        OVER   = 3'd6
    } phaseT;

    phaseT              stateQ, stateD;
    logic [EW-1:0]      secretQ, secretD;
    logic [EW-1:0]      entryQ, entryD;
    logic [3:0]         entryCntQ, entryCntD;
    logic               correctQ, correctD;
    logic [3:0]         levelQ, levelD;
    logic [2:0]         livesQ, livesD;
    logic [SCORE_W-1:0] scoreQ, scoreD;
    logic [TW-1:0]      timerQ, timerD;
    logic               randReqQ, randReqD;
    logic               gameOverQ, gameOverD;

    logic [63:0]        stepTotal;
    logic [TW-1:0]      showLen;
    logic [SCORE_W:0]   scoreSum;
    logic [3:0]         levelNext;

    // Window shrinks with level but never below MIN_SHOW; wide math avoids underflow.
    always_comb begin
        stepTotal = '0;
        showLen   = '0;
        if (levelQ != 4'd0) begin
            stepTotal = 64'(levelQ - 4'd1) * 64'(SHOW_STEP);
        end
        if (stepTotal + 64'(MIN_SHOW) >= 64'(SHOW_CYCLES)) begin
            showLen = TW'(MIN_SHOW);
        end else begin
            showLen = TW'(64'(SHOW_CYCLES) - stepTotal);
        end
    end

    always_comb begin
        scoreSum  = {1'b0, scoreQ} + (SCORE_W + 1)'(levelQ);
        levelNext = (levelQ >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : levelQ + 4'd1;
    end

    always_comb begin
        stateD    = stateQ;
        secretD   = secretQ;
        entryD    = entryQ;
        entryCntD = entryCntQ;
        correctD  = correctQ;
        levelD    = levelQ;
        livesD    = livesQ;
        scoreD    = scoreQ;
        timerD    = timerQ;

        case (stateQ)
            IDLE, OVER: begin
                if (bus.start) begin
                    stateD = LOAD;
                    levelD = 4'd1;
                    livesD = 3'(LIVES);
                    scoreD = '0;
                end
            end
            LOAD: begin
                secretD   = bus.rand_val;
                entryD    = '0;
                entryCntD = '0;
                timerD    = showLen;
                stateD    = SHOW;
            end
            SHOW: begin
                if (timerQ <= TW'(1)) begin
                    stateD = ENTRY;
                end else begin
                    timerD = timerQ - TW'(1);
                end
            end
            ENTRY: begin
                // A full entry locks out the keypad until the check.
                if (entryCntQ == 4'(DIGITS)) begin
                    stateD = CHECK;
                end else if (bus.key_clear) begin
                    entryD    = '0;
                    entryCntD = '0;
                end else if (bus.key_valid) begin
                    entryD    = EW'({entryQ, bus.key_digit});
                    entryCntD = entryCntQ + 4'd1;
                end
            end
            CHECK: begin
                correctD = (entryQ == secretQ);
                timerD   = TW'(RESULT_CYCLES);
                stateD   = RESULT;
            end
            RESULT: begin
                if (timerQ <= TW'(1)) begin
                    if (correctQ) begin
                        scoreD = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
                        levelD = levelNext;
                        stateD = LOAD;
                    end else if (livesQ > 3'd1) begin
                        livesD = livesQ - 3'd1;
                        stateD = LOAD;
                    end else begin
                        livesD = '0;
                        stateD = OVER;
                    end
                end else begin
                    timerD = timerQ - TW'(1);
                end
            end
            default: stateD = IDLE;
        endcase

        randReqD  = (stateD == LOAD);
        gameOverD = (stateD == OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= IDLE;
            secretQ   <= '0;
            entryQ    <= '0;
            entryCntQ <= '0;
            correctQ  <= 1'b0;
            levelQ    <= '0;
            livesQ    <= '0;
            scoreQ    <= '0;
            timerQ    <= '0;
            randReqQ  <= 1'b0;
            gameOverQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            secretQ   <= secretD;
            entryQ    <= entryD;
            entryCntQ <= entryCntD;
            correctQ  <= correctD;
            levelQ    <= levelD;
            livesQ    <= livesD;
            scoreQ    <= scoreD;
            timerQ    <= timerD;
            randReqQ  <= randReqD;
            gameOverQ <= gameOverD;
        end
    end

    assign bus.phase     = stateQ;
    assign bus.secret    = secretQ;
    assign bus.entry     = entryQ;
    assign bus.entry_cnt = entryCntQ;
    assign bus.correct   = correctQ;
    assign bus.level     = levelQ;
    assign bus.lives     = livesQ;
    assign bus.score     = scoreQ;
    assign bus.rand_req  = randReqQ;
    assign bus.game_over = gameOverQ;
endmodule
